// File: rtl/siso_tx_scheduler.sv
// siso_tx_scheduler
//   Two-requester round-robin scheduler that serialises one accepted word
//   per frame toward a downstream SISO shift register. A frame is a start bit
//   (0), WIDTH payload bits LSB first, and a stop bit (1). Each bit is held
//   for BIT_CYCLES clocks.
//
// Ports
//   clk                 : clock, all state changes on the rising edge
//   rst                 : synchronous active-high reset
//   reqN_valid/_data    : requester N offers a WIDTH-bit word (N = 0, 1)
//   reqN_ready          : requester N word taken this cycle when valid is high
//   serial_out          : bit driven to the downstream serial_in
//   shift_en            : downstream shift strobe, last clock of each bit
//   busy                : a frame is in progress
//   grant_id            : requester owning the current or last frame
//   frame_done          : one-cycle pulse on the last clock of the stop bit
module siso_tx_scheduler #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             serial_out,
  output logic             shift_en,
  output logic             busy,
  output logic             grant_id,
  output logic             frame_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic             serial_q, shift_q, busy_q, done_q;
  logic             cyc_end;

  assign cyc_end = (cyc_q == CYC_LAST);

  // Round-robin: with both requesters valid, the one that did not win last
  // time is offered ready. Ready is only ever offered while idle.
  always_comb begin
    req0_ready = (state_q == IDLE) && !rst && req0_valid && (!req1_valid || last_q);
    req1_ready = (state_q == IDLE) && !rst && req1_valid && (!req0_valid || !last_q);
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    last_d  = last_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          data_d  = req0_ready ? req0_data : req1_data;
          grant_d = req1_ready;
          last_d  = req1_ready;
          cyc_d   = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (cyc_end) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      DATA: begin
        if (cyc_end) begin
          cyc_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      STOP: begin
        if (cyc_end) begin
          cyc_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for a given state; idle and stop both hold the line high.
  function automatic logic line_level(state_t s, logic [WIDTH-1:0] d, logic [BW-1:0] b);
    case (s)
      START:   line_level = 1'b0;
      DATA:    line_level = d[b];
      default: line_level = 1'b1;
    endcase
  endfunction

  // Outputs are registered from next-state values so they line up with the
  // state they describe, not one clock behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b1;
      grant_q  <= 1'b0;
      serial_q <= 1'b1;
      shift_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      serial_q <= line_level(state_d, data_d, bit_d);
      shift_q  <= (state_d != IDLE) && (cyc_d == CYC_LAST);
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_d == STOP) && (cyc_d == CYC_LAST);
    end
  end

  assign serial_out = serial_q;
  assign shift_en   = shift_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_siso_tx_scheduler.sv
module tb_siso_tx_scheduler;

  localparam int W = 8;

  logic clk;
  logic rst;
  logic         v0  [2];
  logic         v1  [2];
  logic [W-1:0] d0  [2];
  logic [W-1:0] d1  [2];
  logic         rd0 [2];
  logic         rd1 [2];
  logic         so  [2];
  logic         se  [2];
  logic         bz  [2];
  logic         gn  [2];
  logic         fd  [2];

  int checks;
  int failures;

  // Instance 0 runs one clock per bit, instance 1 three clocks per bit.
  siso_tx_scheduler #(.WIDTH(W), .BIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(rd0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(rd1[0]),
    .serial_out(so[0]), .shift_en(se[0]), .busy(bz[0]),
    .grant_id(gn[0]), .frame_done(fd[0])
  );

  siso_tx_scheduler #(.WIDTH(W), .BIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(rd0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(rd1[1]),
    .serial_out(so[1]), .shift_en(se[1]), .busy(bz[1]),
    .grant_id(gn[1]), .frame_done(fd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: on accept, the whole expected waveform of the frame
  // is laid out in arrays, then replayed one entry per clock.
  bit m_known;
  bit m_inf   [2];
  int m_pos   [2];
  bit m_grant [2];
  bit m_last  [2];
  bit fser    [2][64];
  bit fsh     [2][64];
  bit ffd     [2][64];

  function automatic int bc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic build_frame(input int i, input logic [W-1:0] d);
    int bc;
    bit b;
    bc = bc_of(i);
    for (int k = 0; k < W + 2; k++) begin
      if (k == 0) b = 1'b0;
      else if (k == W + 1) b = 1'b1;
      else b = d[k-1];
      for (int c = 0; c < bc; c++) begin
        fser[i][k*bc+c] = b;
        fsh[i][k*bc+c]  = (c == bc - 1);
        ffd[i][k*bc+c]  = (k == W + 1) && (c == bc - 1);
      end
    end
  endtask

  task automatic model_cycle(input int i);
    bit a0, a1;
    a0 = v0[i] && (!v1[i] || m_last[i]);
    a1 = v1[i] && (!v0[i] || !m_last[i]);
    if (m_known) begin
      chk($sformatf("serial_out%0d", i), 32'(so[i]), 32'(m_inf[i] ? fser[i][m_pos[i]] : 1'b1));
      chk($sformatf("shift_en%0d", i),   32'(se[i]), 32'(m_inf[i] ? fsh[i][m_pos[i]] : 1'b0));
      chk($sformatf("frame_done%0d", i), 32'(fd[i]), 32'(m_inf[i] ? ffd[i][m_pos[i]] : 1'b0));
      chk($sformatf("busy%0d", i),       32'(bz[i]), 32'(m_inf[i]));
      chk($sformatf("grant_id%0d", i),   32'(gn[i]), 32'(m_grant[i]));
      chk($sformatf("req0_ready%0d", i), 32'(rd0[i]), 32'(!rst && !m_inf[i] && a0));
      chk($sformatf("req1_ready%0d", i), 32'(rd1[i]), 32'(!rst && !m_inf[i] && a1));
    end
    if (rst) begin
      m_inf[i]   = 1'b0;
      m_grant[i] = 1'b0;
      m_last[i]  = 1'b1;
    end else if (m_inf[i]) begin
      m_pos[i]++;
      if (m_pos[i] == (W + 2) * bc_of(i)) m_inf[i] = 1'b0;
    end else if (a0 || a1) begin
      build_frame(i, a0 ? d0[i] : d1[i]);
      m_grant[i] = a1;
      m_last[i]  = a1;
      m_inf[i]   = 1'b1;
      m_pos[i]   = 0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model with the
  // inputs the next rising edge will sample, return just after that edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_cycle(i);
    if (rst) m_known = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic cap_frame(input int i, input int n, output logic [63:0] ser,
                           output int nsh, output int nfd, output int fdpos,
                           output int nbusy, output int shoff);
    ser = '0; nsh = 0; nfd = 0; fdpos = -1; nbusy = 0; shoff = 0;
    for (int k = 0; k < n; k++) begin
      ser[k] = so[i];
      if (se[i]) begin
        nsh++;
        if ((k % bc_of(i)) != bc_of(i) - 1) shoff++;
      end
      if (fd[i]) begin
        nfd++;
        if (fdpos < 0) fdpos = k + 1;
      end
      if (bz[i]) nbusy++;
      tick();
    end
  endtask

  initial begin
    logic [63:0] ser;
    int nsh, nfd, fdpos, nbusy, shoff;
    int nrdy, nidle, nbad;
    checks = 0;
    failures = 0;
    m_known = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0; d0[i] = '0; d1[i] = '0;
      m_inf[i] = 1'b0; m_pos[i] = 0; m_grant[i] = 1'b0; m_last[i] = 1'b1;
    end
    repeat (3) tick();
    chk("rst_serial", 32'(so[0]), 32'd1);
    chk("rst_busy", 32'(bz[0]), 32'd0);
    chk("rst_grant", 32'(gn[0]), 32'd0);
    chk("rst_shift", 32'(se[1]), 32'd0);
    rst = 1'b0;
    tick();

    // Single word 0xA5 from requester 0.
    v0[0] = 1'b1; d0[0] = 8'hA5;
    #1;
    chk("a5_ready0", 32'(rd0[0]), 32'd1);
    tick();
    v0[0] = 1'b0;
    cap_frame(0, 11, ser, nsh, nfd, fdpos, nbusy, shoff);
    chk("a5_bits", 32'(ser[9:0]), 32'(10'b1101001010));
    chk("a5_shifts", 32'(nsh), 32'd10);
    chk("a5_done_pos", 32'(fdpos), 32'd10);
    chk("a5_done_cnt", 32'(nfd), 32'd1);
    chk("a5_busy_len", 32'(nbusy), 32'd10);
    chk("a5_grant", 32'(gn[0]), 32'd0);

    // Both requesters valid after reset: 0 first, then 1, then 0 again.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v0[0] = 1'b1; d0[0] = 8'h3C; v1[0] = 1'b1; d1[0] = 8'hC3;
    #1;
    chk("rr_first_r0", 32'(rd0[0]), 32'd1);
    chk("rr_first_r1", 32'(rd1[0]), 32'd0);
    tick();
    cap_frame(0, 10, ser, nsh, nfd, fdpos, nbusy, shoff);
    chk("rr_data0", 32'(ser[8:1]), 32'h3C);
    chk("rr_idle_r1", 32'(rd1[0]), 32'd1);
    chk("rr_idle_r0", 32'(rd0[0]), 32'd0);
    tick();
    chk("rr_grant1", 32'(gn[0]), 32'd1);
    cap_frame(0, 10, ser, nsh, nfd, fdpos, nbusy, shoff);
    chk("rr_data1", 32'(ser[8:1]), 32'hC3);
    chk("rr_next_r0", 32'(rd0[0]), 32'd1);
    chk("rr_next_r1", 32'(rd1[0]), 32'd0);
    v0[0] = 1'b0; v1[0] = 1'b0;
    tick();

    // Three clocks per bit, requester 1 sends 0x01.
    v1[1] = 1'b1; d1[1] = 8'h01;
    tick();
    v1[1] = 1'b0;
    cap_frame(1, 31, ser, nsh, nfd, fdpos, nbusy, shoff);
    chk("bc3_busy_len", 32'(nbusy), 32'd30);
    chk("bc3_shifts", 32'(nsh), 32'd10);
    chk("bc3_shift_phase", 32'(shoff), 32'd0);
    chk("bc3_done_pos", 32'(fdpos), 32'd30);
    chk("bc3_start", 32'(ser[2:0]), 32'd0);
    chk("bc3_bit0", 32'(ser[5:3]), 32'd7);
    chk("bc3_bit1", 32'(ser[8:6]), 32'd0);
    chk("bc3_grant", 32'(gn[1]), 32'd1);

    // Reset in the middle of data bit 4, then a clean 0x55 frame.
    v0[0] = 1'b1; d0[0] = 8'hF0;
    tick();
    v0[0] = 1'b0;
    repeat (5) tick();
    chk("abort_pre_busy", 32'(bz[0]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_serial", 32'(so[0]), 32'd1);
    chk("abort_busy", 32'(bz[0]), 32'd0);
    chk("abort_done", 32'(fd[0]), 32'd0);
    v0[0] = 1'b1; d0[0] = 8'h55;
    tick();
    v0[0] = 1'b0;
    cap_frame(0, 10, ser, nsh, nfd, fdpos, nbusy, shoff);
    chk("after_abort_bits", 32'(ser[9:0]), 32'(10'b1010101010));
    chk("after_abort_done", 32'(fdpos), 32'd10);

    // Requester 0 held valid: back-to-back frames, one idle clock apart.
    v0[0] = 1'b1; d0[0] = 8'h81;
    #1;
    nrdy = 0; nidle = 0; nbad = 0;
    for (int k = 0; k < 33; k++) begin
      if (rd0[0]) nrdy++;
      if (!bz[0]) nidle++;
      if (rd0[0] && bz[0]) nbad++;
      tick();
    end
    chk("b2b_ready_cnt", 32'(nrdy), 32'd3);
    chk("b2b_idle_cnt", 32'(nidle), 32'd3);
    chk("b2b_ready_busy", 32'(nbad), 32'd0);
    v0[0] = 1'b0;
    tick();

    // Data changed mid-frame with valid held.
    v0[0] = 1'b1; d0[0] = 8'h0F;
    tick();
    d0[0] = 8'hAA;
    cap_frame(0, 10, ser, nsh, nfd, fdpos, nbusy, shoff);
    chk("midchg_first", 32'(ser[8:1]), 32'h0F);
    chk("midchg_ready", 32'(rd0[0]), 32'd1);
    tick();
    v0[0] = 1'b0;
    cap_frame(0, 11, ser, nsh, nfd, fdpos, nbusy, shoff);
    chk("midchg_second", 32'(ser[8:1]), 32'hAA);
    chk("midchg_frame", 32'(nbusy), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/siso_tx_scheduler.md
SISO_TX_SCHEDULER -- requirements
Module: siso_tx_scheduler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning payload bits per frame (WIDTH >= 2).
REQ-002 The block SHALL have parameter BIT_CYCLES, default 1, meaning clocks per serial bit (BIT_CYCLES >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req0_valid, input, 1 bit: requester 0 has a word.
REQ-006 The block SHALL have port req0_data, input, WIDTH bits: requester 0 payload.
REQ-007 The block SHALL have port req0_ready, output, 1 bit: requester 0 word accepted this cycle when valid is also high.
REQ-008 The block SHALL have ports req1_valid, req1_data and req1_ready, identical to requester 0 in direction, width and meaning.
REQ-009 The block SHALL have port serial_out, output, 1 bit: the bit driven to the downstream SISO shift register serial_in.
REQ-010 The block SHALL have port shift_en, output, 1 bit: downstream shift strobe.
REQ-011 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 The block SHALL have port grant_id, output, 1 bit: the requester owning the current or last frame.
REQ-013 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-015 In IDLE, arbitration SHALL be combinational: a single valid requester gets ready; if both are valid, the requester not in last_grant gets ready (round-robin); at most one ready is high per cycle.
REQ-016 Ready SHALL be high only in IDLE and never while rst=1.
REQ-017 On accept (valid & ready), the block SHALL latch data and requester index into grant_id and last_grant, and go to START.
REQ-018 START SHALL drive serial_out=0 for BIT_CYCLES clocks, then go to DATA.
REQ-019 DATA SHALL drive WIDTH bits LSB first, each for BIT_CYCLES clocks, using a bit counter 0..WIDTH-1, then go to STOP.
REQ-020 STOP SHALL drive serial_out=1 for BIT_CYCLES clocks, then go to IDLE.
REQ-021 In IDLE, serial_out SHALL be 1.
REQ-022 shift_en SHALL be high on the last clock of every bit period in START, DATA and STOP, giving WIDTH+2 pulses per frame.
REQ-023 frame_done SHALL pulse on the last clock of STOP, coincident with the final shift_en.
REQ-024 busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-025 A frame SHALL last exactly (WIDTH+2)*BIT_CYCLES clocks, from the clock after accept.
REQ-026 The next accept SHALL be possible in the first IDLE cycle after frame_done, giving a minimum of one idle clock between frames.
REQ-027 Requester inputs SHALL be ignored during a frame; a held valid SHALL be served when the FSM returns to IDLE.
REQ-028 The bit-period counter SHALL wrap at BIT_CYCLES-1; the bit counter SHALL wrap to 0 on leaving DATA.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL enter IDLE and set serial_out=1, shift_en=0, busy=0, frame_done=0, grant_id=0, last_grant=1 (requester 0 wins first), and clear all counters and the data register.
REQ-030 A reset during a frame SHALL abort it: the partial frame is discarded, no frame_done is issued, and the abort is not reported to the requester.

Verification
REQ-031 WIDTH=8, BIT_CYCLES=1, req0 sends 0xA5 -> serial_out over 10 clocks reads 0,1,0,1,0,0,1,0,1,1; 10 shift_en pulses; frame_done on clock 10; grant_id=0.
REQ-032 After reset, both requesters valid with req0=0x3C and req1=0xC3 -> 0x3C sent first, one idle clock, then 0xC3 with grant_id=1; and with both still valid, requester 0 wins next.
REQ-033 BIT_CYCLES=3, req1 sends 0x01 -> frame lasts 30 clocks; each bit holds for 3 clocks; shift_en is high only on every 3rd clock.
REQ-034 rst asserted during DATA bit 4 -> next clock gives serial_out=1, busy=0, with no frame_done; a new request 0x55 then produces a complete, correct frame.
REQ-035 req0 valid held continuously with req1 idle -> back-to-back frames with exactly one IDLE clock between them and req0_ready high only in those IDLE clocks.
REQ-036 A valid asserted during busy, with data changed mid-frame -> the in-flight frame is unchanged, and the new word is accepted in the next IDLE cycle.
